// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters, delayed active-low
// syncs and visible flag, a frame-start pulse and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SYNC_DELAY  = 2,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  output logic [9:0]             DrawX,
  output logic [9:0]             DrawY,
  output logic                   hs,
  output logic                   vs,
  output logic                   blank,
  output logic                   sync,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Sync window bounds may reach 1024, so decodes compare in 11 bits
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_STOP  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_STOP  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [2:0]  SYNC_IDLE = 3'b110;

  logic [9:0]  hc;
  logic [9:0]  vc;
  logic [10:0] hc_wide;
  logic [10:0] vc_wide;
  logic        line_end;
  logic        frame_end;
  logic        hs_raw;
  logic        vs_raw;
  logic        blank_raw;
  logic [2:0]  raw_bits;

  assign line_end  = (hc == H_LAST);
  assign frame_end = line_end && (vc == V_LAST);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (line_end) begin
      hc <= '0;
      vc <= frame_end ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  // The pulse lands on the cycle the counters read (0,0) after a wrap
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= frame_end;
      if (frame_end) begin
        frame_count <= frame_count + FRAME_CNT_W'(1);
      end
    end
  end

  assign hc_wide   = {1'b0, hc};
  assign vc_wide   = {1'b0, vc};
  assign hs_raw    = !((hc_wide >= HS_START) && (hc_wide < HS_STOP));
  assign vs_raw    = !((vc_wide >= VS_START) && (vc_wide < VS_STOP));
  assign blank_raw = (hc_wide < H_VIS) && (vc_wide < V_VIS);
  assign raw_bits  = {hs_raw, vs_raw, blank_raw};

  // Delay matches the downstream ROM-plus-colour-register latency
  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign {hs, vs, blank} = raw_bits;
    end else begin : g_delay
      logic [2:0] stage [SYNC_DELAY];

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_DELAY; i++) begin
            stage[i] <= SYNC_IDLE;
          end
        end else begin
          stage[0] <= raw_bits;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign {hs, vs, blank} = stage[SYNC_DELAY-1];
    end
  endgenerate

  assign DrawX = hc;
  assign DrawY = vc;
  assign sync  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: several parameterisations share one clock and reset;
// a reference raster model feeds an expected-sync queue compared against the DUT.
module tb_vga_timing_gen;

  localparam int SEL_DEF  = 0;
  localparam int SEL_MID  = 1;
  localparam int SEL_TINY = 2;
  localparam int SEL_ZERO = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [9:0] d_x, d_y, m_x, m_y, t_x, t_y, z_x, z_y;
  logic d_hs, d_vs, d_bl, d_sync, d_fs;
  logic m_hs, m_vs, m_bl, m_sync, m_fs;
  logic t_hs, t_vs, t_bl, t_sync, t_fs;
  logic z_hs, z_vs, z_bl, z_sync, z_fs;
  logic [15:0] d_fc, m_fc, z_fc;
  logic [1:0]  t_fc;

  vga_timing_gen u_def (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs),
    .blank(d_bl), .sync(d_sync), .frame_start(d_fs), .frame_count(d_fc));

  vga_timing_gen #(.H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
                   .V_VISIBLE(24), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)) u_mid (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(m_x), .DrawY(m_y), .hs(m_hs), .vs(m_vs),
    .blank(m_bl), .sync(m_sync), .frame_start(m_fs), .frame_count(m_fc));

  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .SYNC_DELAY(1), .FRAME_CNT_W(2)) u_tiny (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(t_x), .DrawY(t_y), .hs(t_hs), .vs(t_vs),
    .blank(t_bl), .sync(t_sync), .frame_start(t_fs), .frame_count(t_fc));

  vga_timing_gen #(.SYNC_DELAY(0)) u_zero (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(z_x), .DrawY(z_y), .hs(z_hs), .vs(z_vs),
    .blank(z_bl), .sync(z_sync), .frame_start(z_fs), .frame_count(z_fc));

  int sel = SEL_DEF;
  logic [9:0]  o_x, o_y;
  logic        o_hs, o_vs, o_bl, o_fs;
  logic [15:0] o_fc;

  always_comb begin
    o_x = d_x; o_y = d_y; o_hs = d_hs; o_vs = d_vs; o_bl = d_bl; o_fs = d_fs; o_fc = d_fc;
    case (sel)
      SEL_MID:  begin o_x = m_x; o_y = m_y; o_hs = m_hs; o_vs = m_vs; o_bl = m_bl; o_fs = m_fs; o_fc = m_fc; end
      SEL_TINY: begin o_x = t_x; o_y = t_y; o_hs = t_hs; o_vs = t_vs; o_bl = t_bl; o_fs = t_fs; o_fc = {14'd0, t_fc}; end
      SEL_ZERO: begin o_x = z_x; o_y = z_y; o_hs = z_hs; o_vs = z_vs; o_bl = z_bl; o_fs = z_fs; o_fc = z_fc; end
      default: ;
    endcase
  end

  // Reference raster description for the selected instance
  int cfg_hv, cfg_hf, cfg_hs, cfg_hb, cfg_vv, cfg_vf, cfg_vs, cfg_vb, cfg_dly;

  logic [2:0] sb_q[$];
  int fs_cyc[$];
  int fc_val[$];
  int sb_bad, draw_bad, vis_cnt, hs_low, vs_low, fs_off, max_x, max_y;
  int hs_fall_x, hs_rise_x, vs_fall_x, vs_fall_y;
  logic first_bl;
  string sb_msg, draw_msg;

  task automatic set_cfg(input int s, input int hv, input int hf, input int hsy, input int hb,
                         input int vv, input int vf, input int vsy, input int vb, input int dly);
    sel = s; cfg_hv = hv; cfg_hf = hf; cfg_hs = hsy; cfg_hb = hb;
    cfg_vv = vv; cfg_vf = vf; cfg_vs = vsy; cfg_vb = vb; cfg_dly = dly;
  endtask

  function automatic logic [2:0] raw_of(input int h, input int v);
    logic hr, vr, br;
    hr = !(h >= cfg_hv + cfg_hf && h < cfg_hv + cfg_hf + cfg_hs);
    vr = !(v >= cfg_vv + cfg_vf && v < cfg_vv + cfg_vf + cfg_vs);
    br = (h < cfg_hv) && (v < cfg_vv);
    return {hr, vr, br};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Model advances one pixel per cycle; expected sync bits queue up behind
  // SYNC_DELAY idle entries and are popped as the DUT presents each cycle
  task automatic run_stream(input int n, input int win);
    int mh, mv;
    logic [2:0] e;
    logic prev_hs, prev_vs;
    int htot, vtot;
    htot = cfg_hv + cfg_hf + cfg_hs + cfg_hb;
    vtot = cfg_vv + cfg_vf + cfg_vs + cfg_vb;
    sb_q.delete(); fs_cyc.delete(); fc_val.delete();
    sb_bad = 0; draw_bad = 0; vis_cnt = 0; hs_low = 0; vs_low = 0; fs_off = 0;
    max_x = 0; max_y = 0; hs_fall_x = -1; hs_rise_x = -1; vs_fall_x = -1; vs_fall_y = -1;
    first_bl = 1'bx; sb_msg = ""; draw_msg = "";
    for (int i = 0; i < cfg_dly; i++) sb_q.push_back(3'b110);
    mh = 0; mv = 0; prev_hs = 1'b1; prev_vs = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (o_x !== 10'(mh) || o_y !== 10'(mv)) begin
        if (draw_bad == 0) draw_msg = $sformatf("cycle %0d got (%0d,%0d) exp (%0d,%0d)", c, o_x, o_y, mh, mv);
        draw_bad++;
      end
      sb_q.push_back(raw_of(mh, mv));
      e = sb_q.pop_front();
      if ({o_hs, o_vs, o_bl} !== e) begin
        if (sb_bad == 0) sb_msg = $sformatf("cycle %0d {hs,vs,blank} got %b exp %b", c, {o_hs, o_vs, o_bl}, e);
        sb_bad++;
      end
      if (c == 0) first_bl = o_bl;
      if (c >= cfg_dly && c < cfg_dly + win) begin
        if (o_bl === 1'b1) vis_cnt++;
        if (o_hs === 1'b0) hs_low++;
        if (o_vs === 1'b0) vs_low++;
      end
      if (prev_hs === 1'b1 && o_hs === 1'b0 && hs_fall_x < 0) hs_fall_x = int'(o_x);
      if (prev_hs === 1'b0 && o_hs === 1'b1 && hs_rise_x < 0) hs_rise_x = int'(o_x);
      if (prev_vs === 1'b1 && o_vs === 1'b0 && vs_fall_x < 0) begin
        vs_fall_x = int'(o_x);
        vs_fall_y = int'(o_y);
      end
      if (o_fs === 1'b1) begin
        fs_cyc.push_back(c);
        fc_val.push_back(int'(o_fc));
        if (o_x !== 10'd0 || o_y !== 10'd0) fs_off++;
      end
      if (int'(o_x) > max_x) max_x = int'(o_x);
      if (int'(o_y) > max_y) max_y = int'(o_y);
      prev_hs = o_hs;
      prev_vs = o_vs;
      if (mh == htot - 1) begin
        mh = 0;
        mv = (mv == vtot - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (1100) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (d_x !== 10'd0 || d_y !== 10'd0) begin errors++; $display("[TB] FAIL reset_coords: got (%0d,%0d) exp (0,0)", d_x, d_y); end
    checks++; if ({d_hs, d_vs, d_bl} !== 3'b110) begin errors++; $display("[TB] FAIL reset_syncs: got %b exp 110", {d_hs, d_vs, d_bl}); end
    checks++; if (d_sync !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync: got %b exp 0", d_sync); end
    checks++; if (d_fs !== 1'b0 || d_fc !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame: got fs=%b fc=%0d exp 0/0", d_fs, d_fc); end
    checks++; if (t_fc !== 2'd0) begin errors++; $display("[TB] FAIL reset_tiny_count: got %0d exp 0", t_fc); end
    checks++; if (m_x !== 10'd0 || m_y !== 10'd0) begin errors++; $display("[TB] FAIL reset_mid_coords: got (%0d,%0d) exp (0,0)", m_x, m_y); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (d_x !== 10'(c)) begin errors++; $display("[TB] FAIL release_drawx: cycle %0d got %0d exp %0d", c, d_x, c); end
      checks++; if (d_bl !== (c >= 2)) begin errors++; $display("[TB] FAIL release_blank: cycle %0d got %b exp %b", c, d_bl, (c >= 2)); end
      @(negedge clk);
    end
  endtask

  task automatic test_horizontal();
    set_cfg(SEL_DEF, 640, 16, 96, 48, 480, 10, 2, 33, 2);
    do_reset();
    run_stream(2402, 2400);
    checks++; if (sb_bad !== 0) begin errors++; $display("[TB] FAIL horiz_scoreboard: %0d mismatches, first %s", sb_bad, sb_msg); end
    checks++; if (draw_bad !== 0) begin errors++; $display("[TB] FAIL horiz_coords: %0d mismatches, first %s", draw_bad, draw_msg); end
    checks++; if (hs_fall_x !== 658) begin errors++; $display("[TB] FAIL hs_fall: DrawX got %0d exp 658", hs_fall_x); end
    checks++; if (hs_rise_x !== 754) begin errors++; $display("[TB] FAIL hs_rise: DrawX got %0d exp 754", hs_rise_x); end
    checks++; if (hs_low !== 288) begin errors++; $display("[TB] FAIL hs_low_3lines: got %0d exp 288", hs_low); end
    checks++; if (vis_cnt !== 1920) begin errors++; $display("[TB] FAIL visible_3lines: got %0d exp 1920", vis_cnt); end
  endtask

  task automatic test_vertical_visible();
    set_cfg(SEL_MID, 64, 4, 8, 4, 24, 2, 2, 2, 2);
    do_reset();
    run_stream(7210, 7200);
    checks++; if (sb_bad !== 0) begin errors++; $display("[TB] FAIL mid_scoreboard: %0d mismatches, first %s", sb_bad, sb_msg); end
    checks++; if (draw_bad !== 0) begin errors++; $display("[TB] FAIL mid_coords: %0d mismatches, first %s", draw_bad, draw_msg); end
    checks++; if (vis_cnt !== 4608) begin errors++; $display("[TB] FAIL visible_3frames: got %0d exp 4608", vis_cnt); end
    checks++; if (vs_low !== 480) begin errors++; $display("[TB] FAIL vs_low_3frames: got %0d exp 480", vs_low); end
    checks++; if (hs_low !== 720) begin errors++; $display("[TB] FAIL hs_low_3frames: got %0d exp 720", hs_low); end
    checks++; if (vs_fall_x !== 2 || vs_fall_y !== 26) begin errors++; $display("[TB] FAIL vs_fall: got (%0d,%0d) exp (2,26)", vs_fall_x, vs_fall_y); end
  endtask

  task automatic test_frame_boundary();
    set_cfg(SEL_MID, 64, 4, 8, 4, 24, 2, 2, 2, 2);
    do_reset();
    run_stream(7210, 7200);
    checks++; if (fs_cyc.size() !== 3) begin errors++; $display("[TB] FAIL frame_pulses: got %0d exp 3", fs_cyc.size()); end
    checks++; if (fs_off !== 0) begin errors++; $display("[TB] FAIL frame_origin: %0d pulses off (0,0) exp 0", fs_off); end
    if (fs_cyc.size() >= 3) begin
      checks++; if (fs_cyc[0] !== 2400) begin errors++; $display("[TB] FAIL first_pulse: cycle got %0d exp 2400", fs_cyc[0]); end
      checks++; if (fs_cyc[1] - fs_cyc[0] !== 2400 || fs_cyc[2] - fs_cyc[1] !== 2400) begin
        errors++; $display("[TB] FAIL pulse_gap: got %0d,%0d exp 2400", fs_cyc[1] - fs_cyc[0], fs_cyc[2] - fs_cyc[1]);
      end
      checks++; if (fc_val[0] !== 1 || fc_val[1] !== 2) begin errors++; $display("[TB] FAIL frame_count: got %0d,%0d exp 1,2", fc_val[0], fc_val[1]); end
    end
  endtask

  task automatic test_wrap();
    int exp_fc[5];
    exp_fc = '{1, 2, 3, 0, 1};
    set_cfg(SEL_TINY, 8, 1, 2, 1, 4, 1, 1, 1, 1);
    do_reset();
    run_stream(430, 420);
    checks++; if (sb_bad !== 0) begin errors++; $display("[TB] FAIL tiny_scoreboard: %0d mismatches, first %s", sb_bad, sb_msg); end
    checks++; if (fc_val.size() !== 5) begin errors++; $display("[TB] FAIL tiny_pulses: got %0d exp 5", fc_val.size()); end
    if (fc_val.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (fc_val[i] !== exp_fc[i]) begin errors++; $display("[TB] FAIL tiny_count_%0d: got %0d exp %0d", i, fc_val[i], exp_fc[i]); end
      end
    end
    checks++; if (max_x !== 11 || max_y !== 6) begin errors++; $display("[TB] FAIL tiny_max: got (%0d,%0d) exp (11,6)", max_x, max_y); end
  endtask

  task automatic test_zero_delay();
    set_cfg(SEL_ZERO, 640, 16, 96, 48, 480, 10, 2, 33, 0);
    do_reset();
    run_stream(1602, 1600);
    checks++; if (sb_bad !== 0) begin errors++; $display("[TB] FAIL zero_scoreboard: %0d mismatches, first %s", sb_bad, sb_msg); end
    checks++; if (first_bl !== 1'b1) begin errors++; $display("[TB] FAIL zero_first_blank: got %b exp 1", first_bl); end
    checks++; if (hs_fall_x !== 656 || hs_rise_x !== 752) begin errors++; $display("[TB] FAIL zero_hs_edges: got %0d/%0d exp 656/752", hs_fall_x, hs_rise_x); end
    checks++; if (vis_cnt !== 1280) begin errors++; $display("[TB] FAIL zero_visible: got %0d exp 1280", vis_cnt); end
  endtask

  // Every scenario resets first, so the tasks can run in any order
  initial begin
    reset_n = 1'b0;
    test_reset();
    test_horizontal();
    test_vertical_visible();
    test_frame_boundary();
    test_wrap();
    test_zero_delay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates VGA raster timing for the display pipeline: free-running horizontal and vertical counters, the DrawX/DrawY pixel coordinates, active-low hs/vs syncs and the active-high "visible" blank flag. It sits directly upstream of every sprite/ROM display stage. Those stages consume DrawX/DrawY combinationally into a synchronous ROM, then register colour. To keep colour aligned with sync, hs/vs/blank are delayed by a parameterised number of cycles relative to the coordinates. It also provides a frame-start pulse and a frame counter for game-logic and animation timing.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch; H_TOTAL = sum = 800, must be ≤ 1024
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width
- V_BACK, 33, vertical back porch; V_TOTAL = sum = 525, must be ≤ 1024
- SYNC_DELAY, 2, pipeline depth (0..4) applied to hs/vs/blank relative to DrawX/DrawY
- FRAME_CNT_W, 16, frame_count width
- vga_clk  in  1  pixel clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- DrawX  out  10  horizontal counter hc, 0..H_TOTAL-1, undelayed
- DrawY  out  10  vertical counter vc, 0..V_TOTAL-1, undelayed
- hs  out  1  horizontal sync, active low, delayed SYNC_DELAY cycles
- vs  out  1  vertical sync, active low, delayed SYNC_DELAY cycles
- blank  out  1  1 = visible pixel, 0 = blanking, delayed SYNC_DELAY cycles
- sync  out  1  composite sync to DAC, tied 0
- frame_start  out  1  one-cycle pulse on frame wrap
- frame_count  out  FRAME_CNT_W  completed-frame counter, wraps modulo 2^FRAME_CNT_W

## Operation
- hc increments every cycle. At H_TOTAL-1 it wraps to 0 and vc increments. vc wraps to 0 when hc wraps at vc = V_TOTAL-1.
- Raw decodes from the counter registers:
  - hs_raw = 0 iff H_VISIBLE+H_FRONT ≤ hc < H_VISIBLE+H_FRONT+H_SYNC (656..751)
  - vs_raw = 0 iff V_VISIBLE+V_FRONT ≤ vc < V_VISIBLE+V_FRONT+V_SYNC (490..491)
  - blank_raw = 1 iff hc < H_VISIBLE and vc < V_VISIBLE
- Delay line: hs/vs/blank equal the raw values from exactly SYNC_DELAY cycles earlier. With SYNC_DELAY = 0 they are the raw decodes of the current counters, with no extra register.
- frame_start is registered. It is 1 in the cycle where the counters read (0,0) after wrapping from (H_TOTAL-1, V_TOTAL-1); 0 otherwise.
- frame_count increments in the same cycle frame_start rises.
- The first frame after reset release produces no frame_start and no increment.
- No enable input; the block free-runs whenever reset_n is high.

## Timing
- Reset (reset_n low, async, immediate): hc = vc = 0, DrawX = DrawY = 0, every delay stage holds hs = 1, vs = 1, blank = 0, frame_start = 0, frame_count = 0, sync = 0.
- First rising edge after release: counters advance to hc = 1. DrawX = 0 is presented during the reset-release cycle.
- Delay-stage reset values emerge for the first SYNC_DELAY cycles after release, so blank = 0 initially even though pixel (0,0) is visible.
- Reset asserted mid-frame: all state returns to reset values within the same cycle. The next frame_start occurs one full frame (H_TOTAL×V_TOTAL cycles) after release.
- Line period: H_TOTAL cycles. Frame period: H_TOTAL×V_TOTAL cycles (420000 default).
- Intermediate arithmetic must not overflow 10 bits. Boundary constants are computed at elaboration.

## Test plan
- Reset: drive reset_n low mid-line (hc≈300, vc≈200) -> all outputs at reset values within the cycle. After release, DrawX counts 0,1,2…; blank = 0 for the first 2 cycles, then 1.
- Horizontal: with defaults, sample hs vs DrawX -> hs goes low exactly 2 cycles after DrawX = 656, returns high 2 cycles after DrawX = 752. Each line has 96 low cycles.
- Vertical/visible: count blank = 1 cycles per frame -> 307200. Count vs low lines -> 2 (1600 cycles), beginning 2 cycles after (DrawX, DrawY) = (0, 490).
- Frame boundary: run 3 frames -> frame_start pulses are exactly 420000 cycles apart, each coinciding with DrawX = DrawY = 0. No pulse in the first frame. frame_count = 2 after the second pulse.
- Wrap: FRAME_CNT_W = 2, reduced timing (H 8/1/2/1, V 4/1/1/1) -> frame_count sequence 1,2,3,0,1. hc never exceeds 11 and vc never exceeds 6.
- SYNC_DELAY = 0 -> blank is 1 in the same cycle as DrawX < 640 and DrawY < 480. hs is low in the same cycle as DrawX = 656.
